// File: rtl/timer_device_if.sv
// Bridge-side bus bundle between the memory-stage bridge and one timer window.
// Zero latency: read data and interrupt are combinational from device state.
// No backpressure: the device accepts every strobed write on the edge it is seen.
//
// Signals:
//   Addr  word select (bridge address bits [3:2])
//   WE    write strobe, already qualified by the pipeline
//   DIn   write data
//   DOut  read data, combinational on Addr
//   IRQ   level interrupt request
interface timer_device_if;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic        IRQ;

    // Bridge / CPU side drives the request, samples the response.
    modport master (
        output Addr,
        output WE,
        output DIn,
        input  DOut,
        input  IRQ
    );

    // Timer device side.
    modport slave (
        input  Addr,
        input  WE,
        input  DIn,
        output DOut,
        output IRQ
    );
endinterface

// File: rtl/timer_device.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, one-shot or auto-reload.
// Reads are zero-latency (DOut combinational on Addr); writes land on the strobed edge.
// Never stalls the bridge: every access completes in the cycle it is presented.
//
// Ports:
//   Clk    system clock, rising-edge state updates
//   Reset  asynchronous active-low reset
//   bus    timer_device_if.slave: Addr, WE, DIn in; DOut, IRQ out
//
// Register map (by Addr): 0 CTRL {IM, Mode[1:0], Enable}, 1 PRESET, 2 COUNT (RO), 3 reads 0.
module timer_device (
    input  logic          Clk,
    input  logic          Reset,
    timer_device_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    state_t      state;
    state_t      state_nxt;

    logic        ctrl_en;
    logic [1:0]  ctrl_mode;
    logic        ctrl_im;
    logic [31:0] preset;
    logic [31:0] count;
    logic [31:0] count_nxt;
    logic        irq_flag;

    logic        wr_ctrl;
    logic        wr_preset;
    logic        en_eff;
    logic        auto_reload;
    logic        en_clr;
    logic        flag_set;
    logic        fsm_flag_clr;
    logic        flag_clr;
    logic [31:0] dout;

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    assign wr_ctrl   = bus.WE && (bus.Addr == A_CTRL);
    assign wr_preset = bus.WE && (bus.Addr == A_PRESET);

    // A CTRL write clearing Enable must stop LOAD/CNT on the same edge, so the
    // running states look at the value being written rather than the stale one.
    assign en_eff = wr_ctrl ? bus.DIn[0] : ctrl_en;

    // Mode 1x behaves as one-shot; only 01 reloads.
    assign auto_reload = (ctrl_mode == 2'b01);

    // ------------------------------------------------------------------
    // Counter FSM: next state and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        en_clr       = 1'b0;
        flag_set     = 1'b0;
        fsm_flag_clr = 1'b0;

        case (state)
            ST_IDLE: begin
                // Registered Enable: a start write reaches LOAD one edge later.
                if (ctrl_en) begin
                    state_nxt = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (!en_eff) begin
                    state_nxt = ST_IDLE;
                end else begin
                    count_nxt = preset;
                    state_nxt = ST_CNT;
                end
            end

            ST_CNT: begin
                if (!en_eff) begin
                    state_nxt = ST_IDLE;
                end else if (count == 32'd0) begin
                    state_nxt = ST_INT;
                    flag_set  = 1'b1;
                end else begin
                    count_nxt = count - 32'd1;
                end
            end

            ST_INT: begin
                if (auto_reload) begin
                    fsm_flag_clr = 1'b1;
                    state_nxt    = ST_LOAD;
                end else begin
                    en_clr    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Any CPU write to CTRL or PRESET acknowledges the interrupt.
    assign flag_clr = wr_ctrl || wr_preset || fsm_flag_clr;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
            count <= 32'd0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // CPU write beats the one-shot Enable clear when both land together.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ctrl_en   <= 1'b0;
            ctrl_mode <= 2'b00;
            ctrl_im   <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_en   <= bus.DIn[0];
            ctrl_mode <= bus.DIn[2:1];
            ctrl_im   <= bus.DIn[3];
        end else if (en_clr) begin
            ctrl_en   <= 1'b0;
        end
    end

    // PRESET only feeds COUNT through LOAD, so a write mid-count waits for reload.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            preset <= 32'd0;
        end else if (wr_preset) begin
            preset <= bus.DIn;
        end
    end

    // Set has priority so an expiry coinciding with an acknowledge is never lost.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            irq_flag <= 1'b0;
        end else if (flag_set) begin
            irq_flag <= 1'b1;
        end else if (flag_clr) begin
            irq_flag <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read mux and interrupt
    // ------------------------------------------------------------------
    always_comb begin
        dout = 32'd0;
        case (bus.Addr)
            A_CTRL:   dout = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
            A_PRESET: dout = preset;
            A_COUNT:  dout = count;
            default:  dout = 32'd0;
        endcase
    end

    assign bus.DOut = dout;
    assign bus.IRQ  = ctrl_im & irq_flag;

endmodule

// File: tb/tb_timer_device.sv
// Testbench for timer_device: randomized and directed register traffic against a
// per-edge reference model; expected read data / IRQ are queued by the driver and
// compared by an independent monitor on the falling edge.
module tb_timer_device;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;

    timer_device_if bus();

    timer_device dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] dout;
        logic        irq;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the timer as a phase (idle / loading / running /
    // expired) plus plain integers, advanced once per rising edge.
    // ------------------------------------------------------------------
    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_EXP  = 3;

    int          m_phase;
    logic        m_en;
    logic [1:0]  m_mode;
    logic        m_im;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_flag;

    task automatic model_reset();
        m_phase  = PH_IDLE;
        m_en     = 1'b0;
        m_mode   = 2'b00;
        m_im     = 1'b0;
        m_preset = 32'd0;
        m_count  = 32'd0;
        m_flag   = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input logic we, input logic [1:0] addr, input logic [31:0] din);
        bit   wc, wp, run_en, set, clr;
        int   ph;
        logic en_after;
        wc       = we && (addr == 2'd0);
        wp       = we && (addr == 2'd1);
        run_en   = wc ? din[0] : m_en;
        set      = 0;
        clr      = wc || wp;
        ph       = m_phase;
        en_after = m_en;
        if (m_phase == PH_IDLE) begin
            if (m_en) ph = PH_LOAD;
        end else if (m_phase == PH_LOAD) begin
            if (!run_en) ph = PH_IDLE;
            else begin
                m_count = m_preset;
                ph      = PH_RUN;
            end
        end else if (m_phase == PH_RUN) begin
            if (!run_en) ph = PH_IDLE;
            else if (m_count == 0) begin
                ph  = PH_EXP;
                set = 1;
            end else m_count = m_count - 1;
        end else begin
            if (m_mode == 2'b01) begin
                clr = 1;
                ph  = PH_LOAD;
            end else begin
                en_after = 1'b0;
                ph       = PH_IDLE;
            end
        end
        if (wc) begin
            m_en   = din[0];
            m_mode = din[2:1];
            m_im   = din[3];
        end else begin
            m_en = en_after;
        end
        if (wp) m_preset = din;
        if (set) m_flag = 1'b1;
        else if (clr) m_flag = 1'b0;
        m_phase = ph;
    endtask

    // ------------------------------------------------------------------
    // Driver: present an access, queue what the device must show this
    // cycle, then advance model and DUT across the rising edge.
    // Returns at posedge+1 with the same inputs still applied.
    // ------------------------------------------------------------------
    task automatic do_cycle(input logic we, input logic [1:0] addr, input logic [31:0] din);
        exp_t e;
        bus.WE   = we;
        bus.Addr = addr;
        bus.DIn  = din;
        e.dout   = m_read(addr);
        e.irq    = m_im & m_flag;
        sb_q.push_back(e);
        @(posedge Clk);
        model_step(we, addr, din);
        #1;
    endtask

    task automatic peek(input logic [1:0] addr, input string name, input logic [31:0] exp);
        do_cycle(1'b0, addr, 32'd0);
        check(name, bus.DOut, exp);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_dout", bus.DOut, e.dout);
                check("sb_irq", {31'd0, bus.IRQ}, {31'd0, e.irq});
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        int rise, hi, bad, found, npulse, last_rise, bad_gap, bad_width;
        logic prev;

        bus.WE   = 1'b0;
        bus.Addr = 2'd0;
        bus.DIn  = 32'd0;
        model_reset();

        // Reset state, before any edge is seen.
        #2;
        check("reset_ctrl", bus.DOut, 32'd0);
        check("reset_irq", {31'd0, bus.IRQ}, 32'd0);
        bus.Addr = 2'd2;
        #1;
        check("reset_count", bus.DOut, 32'd0);
        #9;
        Reset = 1'b1;
        @(posedge Clk);
        #1;

        // Reset and readback.
        do_cycle(1'b1, 2'd1, 32'h10);
        do_cycle(1'b1, 2'd0, 32'hFFFF_FFF6);
        peek(2'd0, "rb_ctrl", 32'h6);
        peek(2'd1, "rb_preset", 32'h10);
        peek(2'd2, "rb_count", 32'h0);
        peek(2'd3, "rb_rsvd", 32'h0);
        check("rb_irq", {31'd0, bus.IRQ}, 32'd0);

        // One-shot expiry, PRESET=5, start at edge 0.
        do_cycle(1'b1, 2'd1, 32'd5);
        do_cycle(1'b1, 2'd0, 32'h9);
        rise = -1;
        for (int k = 1; k <= 12; k++) begin
            do_cycle(1'b0, 2'd0, 32'd0);
            if (bus.IRQ && rise < 0) rise = k;
            if (k == 9) check("os_ctrl_e9", bus.DOut, 32'h8);
        end
        check("os_irq_rise_edge", rise, 32'd8);
        peek(2'd2, "os_count", 32'd0);
        check("os_irq_hold", {31'd0, bus.IRQ}, 32'd1);
        do_cycle(1'b1, 2'd0, 32'h8);
        check("os_irq_fall", {31'd0, bus.IRQ}, 32'd0);

        // Auto-reload, PRESET=3: pulses one cycle wide, six cycles apart.
        do_cycle(1'b1, 2'd1, 32'd3);
        do_cycle(1'b1, 2'd0, 32'hB);
        prev = 1'b0; last_rise = -1; npulse = 0; bad_gap = 0; bad_width = 0;
        for (int k = 1; k <= 40; k++) begin
            do_cycle(1'b0, 2'd2, 32'd0);
            if (bus.IRQ && !prev) begin
                if (last_rise >= 0 && (k - last_rise) != 6) bad_gap++;
                last_rise = k;
                npulse++;
            end
            if (bus.IRQ && prev) bad_width++;
            prev = bus.IRQ;
        end
        check("ar_enough_pulses", {31'd0, npulse >= 4}, 32'd1);
        check("ar_bad_gaps", bad_gap, 32'd0);
        check("ar_wide_pulses", bad_width, 32'd0);
        do_cycle(1'b1, 2'd0, 32'h0);
        repeat (3) do_cycle(1'b0, 2'd2, 32'd0);

        // Masked expiry: IRQ must stay low.
        do_cycle(1'b1, 2'd1, 32'd4);
        do_cycle(1'b1, 2'd0, 32'h1);
        hi = 0;
        for (int k = 0; k < 15; k++) begin
            do_cycle(1'b0, 2'd2, 32'd0);
            if (bus.IRQ) hi++;
        end
        check("mask_irq_quiet", hi, 32'd0);

        // Restart, then stop with Enable=0 while COUNT=2.
        do_cycle(1'b1, 2'd0, 32'h9);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            do_cycle(1'b0, 2'd2, 32'd0);
            if (m_phase == PH_RUN && m_count == 32'd2) found = 1;
        end
        check("stop_reached_count2", found, 32'd1);
        do_cycle(1'b1, 2'd0, 32'h8);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            do_cycle(1'b0, 2'd2, 32'd0);
            if (bus.DOut !== 32'd2 || bus.IRQ !== 1'b0) bad++;
        end
        check("stop_frozen", bad, 32'd0);

        // PRESET=0: IRQ after edge 3.
        do_cycle(1'b1, 2'd1, 32'd0);
        do_cycle(1'b1, 2'd0, 32'h9);
        rise = -1;
        for (int k = 1; k <= 6; k++) begin
            do_cycle(1'b0, 2'd2, 32'd0);
            if (bus.IRQ && rise < 0) rise = k;
        end
        check("p0_irq_edge", rise, 32'd3);

        // Writes to COUNT and the unused word are ignored.
        do_cycle(1'b1, 2'd2, 32'hFF);
        peek(2'd2, "wr_count_ignored", 32'd0);
        do_cycle(1'b1, 2'd3, 32'h55);
        peek(2'd3, "wr_rsvd_ignored", 32'd0);
        check("wr_count_keeps_irq", {31'd0, bus.IRQ}, 32'd1);

        // CTRL write on the same edge as CNT->INT: the expiry still lands.
        do_cycle(1'b1, 2'd1, 32'd2);
        do_cycle(1'b1, 2'd0, 32'h9);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            do_cycle(1'b0, 2'd2, 32'd0);
            if (m_phase == PH_RUN && m_count == 32'd0) found = 1;
        end
        check("coll_reached_zero", found, 32'd1);
        do_cycle(1'b1, 2'd0, 32'h9);
        check("coll_irq_set", {31'd0, bus.IRQ}, 32'd1);
        repeat (3) do_cycle(1'b0, 2'd0, 32'd0);

        // Reset mid-count at COUNT=7.
        do_cycle(1'b1, 2'd1, 32'd20);
        do_cycle(1'b1, 2'd0, 32'h9);
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            do_cycle(1'b0, 2'd2, 32'd0);
            if (m_phase == PH_RUN && m_count == 32'd7) found = 1;
        end
        check("rst_reached_count7", found, 32'd1);
        check("pre_rst_count", bus.DOut, 32'd7);
        #2;
        Reset = 1'b0;
        model_reset();
        #1;
        check("rst_count_now", bus.DOut, 32'd0);
        check("rst_irq_now", {31'd0, bus.IRQ}, 32'd0);
        repeat (2) @(posedge Clk);
        #3;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            do_cycle(1'b0, 2'd2, 32'd0);
            if (bus.DOut !== 32'd0) bad++;
        end
        check("post_rst_no_count", bad, 32'd0);

        // Randomized traffic against the model.
        for (int k = 0; k < 500; k++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r < 2) do_cycle(1'b1, 2'd0, $urandom);
            else if (r == 2) do_cycle(1'b1, 2'd1, 32'($urandom_range(0, 6)));
            else if (r == 3) do_cycle(1'b1, 2'($urandom_range(2, 3)), $urandom);
            else do_cycle(1'b0, 2'($urandom_range(0, 3)), $urandom);
        end

        // Let the monitor consume the last entry, bounded.
        for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(negedge Clk);
        #1;
        check("sb_drained", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/timer_device.md
# timer_device

Memory-mapped countdown timer that responds to bridge accesses from the pipeline's memory stage at word offsets 0x0–0xB of its window (0x7F00 base for timer 0). It decodes the bridge write strobe, address and write data, returns combinational read data on the same cycle, and raises an interrupt line that feeds one bit of `HWInt`. Sequential core: a four-state counter FSM with one-shot and auto-reload modes.

## Interface
- No parameters.
- `Clk`  in  1  system clock; all state updates on rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Addr`  in  2  word select, bridge address bits [3:2].
- `WE`  in  1  write strobe. Already gated by the pipeline against interrupts and word-only access.
- `DIn`  in  32  write data (`PrWD`).
- `DOut`  out  32  read data (`PrRD` source), combinational on `Addr`.
- `IRQ`  out  1  interrupt request, level.

## Operation
- Register map (by `Addr`):
  - 0 = CTRL, read/write.
    - [0] Enable.
    - [2:1] Mode: 00 one-shot, 01 auto-reload; 1x is treated as 00.
    - [3] IM, interrupt mask; 1 = IRQ enabled.
    - [31:4] read 0, writes ignored.
  - 1 = PRESET, 32-bit, read/write.
  - 2 = COUNT, read-only; writes ignored.
  - 3 reads 0; writes ignored.
- Internal flag `irq_flag`. `IRQ = CTRL[3] & irq_flag`.
- FSM states IDLE, LOAD, CNT, INT:
  - IDLE: Enable=1 -> LOAD.
  - LOAD: COUNT <= PRESET; -> CNT.
  - CNT, priority order:
    - Enable=0 -> IDLE; COUNT holds.
    - COUNT==0 -> INT, `irq_flag` <= 1.
    - Otherwise COUNT <= COUNT-1.
  - INT:
    - one-shot: Enable <= 0, -> IDLE; `irq_flag` stays set.
    - auto-reload: `irq_flag` <= 0, -> LOAD.
- `irq_flag` is cleared by any CPU write to CTRL or PRESET, and by reset.
- Simultaneous events:
  - CPU write to CTRL and the FSM clearing Enable (INT, one-shot) on the same edge: CPU value wins, and `irq_flag` is cleared.
  - CPU write clearing `irq_flag` and CNT setting it on the same edge: set wins. An expiry is never lost.
- A PRESET write while counting does not change COUNT until the next LOAD.
- A CTRL write with Enable=0 during LOAD or CNT stops counting: next state is IDLE, COUNT is frozen.
- PRESET=0: LOAD writes 0, CNT goes to INT on the next edge.
- COUNT arithmetic is unsigned 32-bit. COUNT never decrements below 0, so no wrap-around.

## Timing
- Reset (async, Reset=0):
  - CTRL=0, PRESET=0, COUNT=0, state IDLE, `irq_flag`=0.
  - IRQ=0 immediately; DOut reflects zeros.
- Reads have zero latency: DOut is valid in the same cycle as `Addr`.
- Writes take effect at the rising edge where WE=1.
- One-shot, PRESET=N, write CTRL=0x9 at edge 0:
  - edge 1: LOAD.
  - edge 2: COUNT=N.
  - edge 2+N: COUNT=0.
  - edge 3+N: INT; IRQ rises.
  - edge 4+N: IDLE, CTRL[0]=0. IRQ holds until a CTRL/PRESET write.
- Auto-reload: IRQ is a one-cycle pulse. Period is N+3 cycles between pulses.
- Reset asserted mid-count: everything returns to reset values at once. Counting resumes only after a new Enable write.

## Test plan
- Reset and readback:
  - Stimulus: deassert reset; write PRESET=0x10, CTRL=0xFFFF_FFF6; read Addr 0, 1, 2, 3.
  - Required: reads of 0x6, 0x10, 0x0, 0x0 respectively; IRQ=0.
- One-shot expiry:
  - Stimulus: PRESET=5; write CTRL=0x9 at edge 0.
  - Required: IRQ rises after edge 8, CTRL reads 0x8 after edge 9, COUNT reads 0.
  - Follow-up: write CTRL=0x8. Required: IRQ falls after that edge.
- Auto-reload:
  - Stimulus: PRESET=3, CTRL=0xB.
  - Required: IRQ 1-cycle pulses exactly 6 cycles apart, at least 4 pulses; COUNT sequence 3,2,1,0 repeats.
- Mask and stop:
  - Stimulus: PRESET=4, CTRL=0x1 (IM=0).
  - Required: IRQ stays 0 through expiry.
  - Stimulus: restart with CTRL=0x9, then write CTRL=0x8 while COUNT=2.
  - Required: COUNT frozen at 2, no IRQ for 20 cycles.
- Boundary and collision cases:
  - Stimulus: PRESET=0 with CTRL=0x9.
  - Required: IRQ after edge 3.
  - Stimulus: write COUNT=0xFF.
  - Required: write ignored.
  - Stimulus: CTRL write landing on the same edge as CNT->INT.
  - Required: `irq_flag` still set.
- Reset mid-count:
  - Stimulus: pull Reset low between edges with COUNT=7.
  - Required: COUNT=0 and IRQ=0 immediately, with no clock edge; no counting after release.
